apb_rr_master: RTL and testbench

APB_RR_MASTER -- requirements
Module: apb_rr_master

---
 rtl/apb_rr_master.sv | 194 +++++++++++++++++++
 tb/tb_apb_rr_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - two-requester round-robin APB master
//
// Purpose: arbitrates two simple request/done clients onto one APB master
// port. Each granted transfer runs IDLE -> SETUP -> ACCESS -> IDLE, so
// at least one IDLE cycle separates transfers. All outputs are registered.
//
// Optional feature macro: APB_ARB_TIMEOUT_EN. When defined, an ACCESS phase
// that sees no pready for TIMEOUT_CYC cycles completes with err=1, rdata=0.
//
// Ports:
//   pclk, presetn          clock (rising edge), async active-low reset
//   req0/1, we0/1          requester request (held until done) and direction
//   addr0/1, wdata0/1      requester address and write data
//   done0/1                one-cycle completion pulse per requester
//   rdata, err             read data / error status, valid with done
//   busy                   high whenever the FSM is not in IDLE
//   psel, penable, pwrite  APB master controls
//   paddr, pwdata          APB address and write data
//   prdata, pready, pslverr APB slave response

module apb_rr_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state, state_nxt;

  // last: requester served most recently. Reset value 1 makes requester 0
  // win the first contended arbitration.
  logic last, last_nxt;
  logic gnt, gnt_nxt;
  logic sel;

  logic              done0_nxt, done1_nxt, err_nxt, busy_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt, rdata_nxt;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt, cnt_nxt;
`else
  // TIMEOUT_CYC only shapes logic when the timeout is compiled in.
  if (TIMEOUT_CYC < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state   <= IDLE;
      last    <= 1'b1;
      gnt     <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      rdata   <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt     <= '0;
`endif
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      gnt     <= gnt_nxt;
      done0   <= done0_nxt;
      done1   <= done1_nxt;
      err     <= err_nxt;
      busy    <= busy_nxt;
      psel    <= psel_nxt;
      penable <= penable_nxt;
      pwrite  <= pwrite_nxt;
      paddr   <= paddr_nxt;
      pwdata  <= pwdata_nxt;
      rdata   <= rdata_nxt;
`ifdef APB_ARB_TIMEOUT_EN
      cnt     <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    gnt_nxt     = gnt;
    done0_nxt   = 1'b0;
    done1_nxt   = 1'b0;
    err_nxt     = err;
    busy_nxt    = busy;
    psel_nxt    = psel;
    penable_nxt = penable;
    pwrite_nxt  = pwrite;
    paddr_nxt   = paddr;
    pwdata_nxt  = pwdata;
    rdata_nxt   = rdata;
    sel         = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    cnt_nxt     = cnt;
`endif

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          // Contended: serve whoever was not served last. Single: serve it.
          sel         = (req0 && req1) ? ~last : req1;
          gnt_nxt     = sel;
          pwrite_nxt  = sel ? we1 : we0;
          paddr_nxt   = sel ? addr1 : addr0;
          pwdata_nxt  = sel ? wdata1 : wdata0;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          busy_nxt    = 1'b1;
          state_nxt   = SETUP;
        end
      end

      SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
        cnt_nxt     = '0;
`endif
      end

      ACCESS: begin
        if (pready) begin
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          busy_nxt    = 1'b0;
          done0_nxt   = ~gnt;
          done1_nxt   = gnt;
          err_nxt     = pslverr;
          rdata_nxt   = pwrite ? rdata : prdata;
          last_nxt    = gnt;
          state_nxt   = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt == CNT_LAST) begin
          psel_nxt    = 1'b0;
          penable_nxt = 1'b0;
          busy_nxt    = 1'b0;
          done0_nxt   = ~gnt;
          done1_nxt   = gnt;
          err_nxt     = 1'b1;
          rdata_nxt   = '0;
          last_nxt    = gnt;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - self-checking bench for apb_rr_master
module tb_apb_rr_master;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, err, busy, psel, penable, pwrite;
  logic [31:0] rdata, paddr, pwdata, prdata;
  logic        pready, pslverr;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [logic [31:0]];

  always #5 pclk = ~pclk;

  apb_rr_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .pclk(pclk), .presetn(presetn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic set_req(input int i, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (i == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {psel, penable, pwrite, done0, done1, err, busy}, 7'h0);
    check({tag, "_bus"}, {paddr, pwdata, rdata}, 96'h0);
  endtask

  task automatic do_reset();
    presetn = 1'b0;
    pready = 1'b0;
    pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
  endtask

  // One requester transfer; slave answers pready in ACCESS cycle wait_cyc
  // (0 = never). Bounded to 60 cycles.
  task automatic xfer(input int who, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int wait_cyc, input logic serr,
                      output int ps_n, output int pe_n, output int acc_n, output int lat,
                      output logic got_done, output logic [31:0] got_rd, output logic got_err);
    ps_n = 0; pe_n = 0; acc_n = 0; lat = -1;
    got_done = 1'b0; got_rd = '0; got_err = 1'b0;
    set_req(who, 1'b1, w, a, d);
    for (int c = 0; c < 60 && !got_done; c++) begin
      @(negedge pclk);
      if (done0 || done1) begin
        got_done = 1'b1;
        check("xfer_done_who", {done1, done0}, (who == 1) ? 2'b10 : 2'b01);
        got_rd = rdata;
        got_err = err;
        pready = 1'b0;
        pslverr = 1'b0;
        set_req(who, 1'b0, w, a, d);
        if (w && !serr && wait_cyc > 0) mem[a] = d;
      end else begin
        if (psel) begin
          ps_n++;
          if (lat < 0) lat = c;
        end
        if (penable) pe_n++;
        if (psel && penable) begin
          acc_n++;
          prdata = rd_mem(paddr);
          pready = (wait_cyc > 0) && (acc_n == wait_cyc);
          pslverr = pready && serr;
        end else begin
          pready = 1'b0;
        end
      end
    end
    check("xfer_completed", got_done, 1'b1);
  endtask

  // Random-phase model state
  bit          act [2];
  logic        t_we [2];
  logic [31:0] t_addr [2];
  logic [31:0] t_wdata [2];

  initial begin
    int ps, pe, ac, lat;
    logic dn, er;
    logic [31:0] rd;
    bit seen;
    int order [$];
    int cur, acc, ndone, g;
    bit in_flight, last_m;
    logic exp_err;
    logic [31:0] exp_rd, pend_rd;

    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    pready = 1'b0; pslverr = 1'b0; prdata = '0;

    // Reset values
    #12;
    check_reset_outputs("reset");
    @(negedge pclk);
    presetn = 1'b1;

    // Write 0x5 <= DEADBEEF, pready on 2nd ACCESS cycle, first grant right after release
    xfer(0, 1'b1, 32'h5, 32'hDEADBEEF, 2, 1'b0, ps, pe, ac, lat, dn, rd, er);
    check("wr_first_grant_lat", lat, 0);
    check("wr_psel_cycles", ps, 3);
    check("wr_penable_cycles", pe, 2);
    check("wr_err", er, 1'b0);

    // Read it back
    xfer(0, 1'b0, 32'h5, 32'h0, 1, 1'b0, ps, pe, ac, lat, dn, rd, er);
    check("rd_data", rd, 32'hDEADBEEF);
    check("rd_err", er, 1'b0);
    check("rd_psel_cycles", ps, 2);

    // Slave error, then a good transfer clears err
    xfer(0, 1'b1, 32'h40, 32'h1234_5678, 3, 1'b1, ps, pe, ac, lat, dn, rd, er);
    check("slverr_err", er, 1'b1);
    check("slverr_rdata_hold", rd, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h5, 32'h0, 1, 1'b0, ps, pe, ac, lat, dn, rd, er);
    check("after_err_err", er, 1'b0);
    check("after_err_rdata", rd, 32'hDEADBEEF);

    // Reset mid-ACCESS; pointer currently favours requester 1
    set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge pclk);
      if (psel && penable) seen = 1'b1;
    end
    check("rst_reach_access", seen, 1'b1);
    #2 presetn = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge pclk);
    check("rst_no_done", {done1, done0}, 2'b00);
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    presetn = 1'b1;
    @(negedge pclk);
    check("rst_grant0", {psel, penable, pwrite, paddr}, {3'b100, 32'h10});
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    do_reset();

    // Both requesters held from reset: order 0,1,0,1
    set_req(0, 1'b1, 1'b1, 32'h20, 32'hA0A0_A0A0);
    set_req(1, 1'b1, 1'b1, 32'h24, 32'hB1B1_B1B1);
    do_reset();
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      @(negedge pclk);
      if (c == 0) check("rr_first_edge", {psel, paddr}, {1'b1, 32'h20});
      if (done0 || done1) begin
        check("rr_done_onehot", done0 ^ done1, 1'b1);
        order.push_back(done1 ? 1 : 0);
        if (order.size() == 4) begin
          set_req(0, 1'b0, 1'b0, '0, '0);
          set_req(1, 1'b0, 1'b0, '0, '0);
        end
      end
      pready = psel && penable;
      prdata = '0;
      pslverr = 1'b0;
    end
    pready = 1'b0;
    check("rr_count", order.size(), 4);
    foreach (order[k]) check($sformatf("rr_order_%0d", k), order[k], k % 2);

    // pready never arrives
`ifdef APB_ARB_TIMEOUT_EN
    xfer(0, 1'b0, 32'h5, 32'h0, 0, 1'b0, ps, pe, ac, lat, dn, rd, er);
    check("to_access_cycles", ac, 16);
    check("to_err", er, 1'b1);
    check("to_rdata", rd, 32'h0);
`else
    set_req(0, 1'b1, 1'b0, 32'h5, 32'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge pclk);
      prdata = 32'h1111_2222;
      if (done0 || done1) seen = 1'b1;
    end
    check("nto_stuck", {busy, psel, penable}, 3'b111);
    check("nto_no_done", seen, 1'b0);
    set_req(0, 1'b0, 1'b0, '0, '0);
`endif

    // Randomized traffic against the transaction-level model
    do_reset();
    act[0] = 0; act[1] = 0;
    in_flight = 0; last_m = 1; cur = 0; acc = 0; ndone = 0;
    exp_err = 1'b0; exp_rd = 32'h0; pend_rd = 32'h0;
    repeat (3000) begin
      @(negedge pclk);
      if (done0 || done1) begin
        check("rnd_done_id", {done1, done0}, in_flight ? (cur == 1 ? 2'b10 : 2'b01) : 2'b00);
        check("rnd_idle_at_done", {psel, penable, busy}, 3'b000);
        if (in_flight) begin
          if (!t_we[cur]) exp_rd = pend_rd;
          check("rnd_rdata", rdata, exp_rd);
          check("rnd_err", err, exp_err);
          if (t_we[cur] && !exp_err) mem[t_addr[cur]] = t_wdata[cur];
          last_m = cur[0];
          act[cur] = 0;
          set_req(cur, 1'b0, 1'b0, '0, '0);
          ndone++;
        end
        in_flight = 0;
        pready = 1'b0;
        pslverr = 1'b0;
      end else if (psel && !penable) begin
        check("rnd_grant_while_busy", in_flight, 1'b0);
        check("rnd_grant_has_req", req0 | req1, 1'b1);
        g = (req0 && req1) ? (last_m ? 0 : 1) : (req1 ? 1 : 0);
        check("rnd_grant", {busy, pwrite, paddr, pwdata}, {1'b1, t_we[g], t_addr[g], t_wdata[g]});
        cur = g; in_flight = 1; acc = 0;
        if ($urandom % 4 == 0) set_req(g, 1'b0, ~t_we[g], $urandom, $urandom);
        pready = 1'b0;
      end else if (psel && penable) begin
        check("rnd_access_hold", {busy, pwrite, paddr, pwdata}, {1'b1, t_we[cur], t_addr[cur], t_wdata[cur]});
        acc++;
        pready = (acc >= 8) || ($urandom % 3 == 0);
        pslverr = pready && ($urandom % 4 == 0);
        prdata = pready ? rd_mem(paddr) : $urandom;
        exp_err = pslverr;
        pend_rd = rd_mem(t_addr[cur]);
      end else begin
        check("rnd_lost_xfer", in_flight, 1'b0);
        pready = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (!act[i] && ($urandom % 3 == 0)) begin
          t_we[i] = 1'($urandom);
          t_addr[i] = $urandom_range(0, 15) * 4;
          t_wdata[i] = $urandom;
          act[i] = 1;
          set_req(i, 1'b1, t_we[i], t_addr[i], t_wdata[i]);
        end
      end
    end
    check("rnd_progress", ndone > 50, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
